// File: rtl/lane_event_arbiter_if.sv
// Event stream from the lane arbiter to the hit-judgement unit.
// Latency: none (wires only). Backpressure: consumer holds ev_ready low to stall the producer.
// Optional release events are carried on ev_release (driven only with LANE_RELEASE_EVT_EN).
interface lane_event_arbiter_if #(
    parameter int LANES = 4,
    parameter int TS_W  = 16
) ();
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic            ev_valid;
    logic            ev_ready;
    logic [LW-1:0]   ev_lane;
    logic [TS_W-1:0] ev_time;
    logic            ev_release;

    modport master (
        output ev_valid,
        output ev_lane,
        output ev_time,
        output ev_release,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_lane,
        input  ev_time,
        input  ev_release,
        output ev_ready
    );
endinterface

// File: rtl/lane_event_arbiter.sv
// Lane key edges -> timestamped events, round-robin onto one stream (release events with LANE_RELEASE_EVT_EN).
// Latency: rising key sampled at edge N is pending at N, on the stream after N+1 when the output is empty.
// Backpressure: output holds while ev_ready=0; one pending slot per requester, extra edges set sticky overflow.
module lane_event_arbiter #(
    parameter int LANES = 4,
    parameter int TS_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic [LANES-1:0] key_in_i,
    input  logic             clr_ovf_i,
    output logic [TS_W-1:0]  game_time_o,
    output logic [LANES-1:0] overflow_o,
    lane_event_arbiter_if.master ev
);

`ifdef LANE_RELEASE_EVT_EN
    localparam int SLOTS_PER_LANE = 2;
`else
    localparam int SLOTS_PER_LANE = 1;
`endif
    localparam int NREQ = LANES * SLOTS_PER_LANE;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q;
    logic [LANES-1:0]  key_q;
    logic [TS_W-1:0]   game_time_q;
    logic [NREQ-1:0]   pend_q;
    logic [NREQ-1:0]   pend_d;
    logic [TS_W-1:0]   ts_q [NREQ];
    logic [LANES-1:0]  ovf_q;
    logic [PW-1:0]     ptr_q;
    logic [LW-1:0]     ev_lane_q;
    logic [TS_W-1:0]   ev_time_q;
    logic              ev_rel_q;

    logic [LANES-1:0]  press;
    logic [NREQ-1:0]   slot_edge;
    logic [NREQ-1:0]   load_hit;
    logic [NREQ-1:0]   drop;
    logic [LANES-1:0]  ovf_set;
    logic              load_ok;
    logic              sel_found;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     cand;
    logic [LW-1:0]     sel_lane;
    logic              sel_rel;

    assign press = key_in_i & ~key_q & {LANES{enable_i}};

`ifdef LANE_RELEASE_EVT_EN
    logic [LANES-1:0] release_edge;
    assign release_edge = ~key_in_i & key_q & {LANES{enable_i}};

    // Slot order per lane is press then release, so the scan interleaves them.
    always_comb begin
        slot_edge = '0;
        for (int l = 0; l < LANES; l++) begin
            slot_edge[2*l]   = press[l];
            slot_edge[2*l+1] = release_edge[l];
        end
    end

    assign sel_lane = sel_idx[PW-1:1];
    assign sel_rel  = sel_idx[0];
`else
    always_comb begin
        slot_edge = '0;
        for (int l = 0; l < LANES; l++) begin
            slot_edge[l] = press[l];
        end
    end

    assign sel_lane = sel_idx;
    assign sel_rel  = 1'b0;
`endif

    assign load_ok = (state_q == IDLE) || ev.ev_ready;

    // First pending slot strictly after the last grant, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!sel_found && pend_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // A slot emptied by this cycle's load can accept a new edge immediately.
    always_comb begin
        ovf_set = '0;
        for (int r = 0; r < NREQ; r++) begin
            load_hit[r] = load_ok && sel_found && (sel_idx == PW'(r));
            drop[r]     = slot_edge[r] && pend_q[r] && !load_hit[r];
            pend_d[r]   = (pend_q[r] && !load_hit[r]) || slot_edge[r];
            if (drop[r]) begin
                ovf_set[r / SLOTS_PER_LANE] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            game_time_q <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            for (int r = 0; r < NREQ; r++) begin
                ts_q[r] <= '0;
            end
        end else begin
            key_q  <= key_in_i;
            pend_q <= pend_d;
            ovf_q  <= (ovf_q & ~{LANES{clr_ovf_i}}) | ovf_set;
            if (tick_i) begin
                game_time_q <= game_time_q + TS_W'(1);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (slot_edge[r] && !drop[r]) begin
                    ts_q[r] <= game_time_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(NREQ - 1);
            ev_lane_q <= '0;
            ev_time_q <= '0;
            ev_rel_q  <= 1'b0;
        end else begin
            if (load_ok && sel_found) begin
                state_q   <= HOLD;
                ptr_q     <= sel_idx;
                ev_lane_q <= sel_lane;
                ev_time_q <= ts_q[sel_idx];
                ev_rel_q  <= sel_rel;
            end else if (state_q == HOLD && ev.ev_ready) begin
                state_q <= IDLE;
            end
        end
    end

    assign ev.ev_valid   = (state_q == HOLD);
    assign ev.ev_lane    = ev_lane_q;
    assign ev.ev_time    = ev_time_q;
    assign ev.ev_release = ev_rel_q;
    assign game_time_o   = game_time_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_lane_event_arbiter.sv
// Bench for lane_event_arbiter: directed scenarios plus randomized traffic against a lane-level event model.
module tb_lane_event_arbiter;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        enable_i  = 1'b1;
    logic        tick_i    = 1'b0;
    logic        clr_ovf_i = 1'b0;
    logic [3:0]  key_in_i  = 4'h0;
    logic [15:0] game_time_o;
    logic [3:0]  overflow_o;

    lane_event_arbiter_if #(.LANES(4), .TS_W(16)) ifc ();

    lane_event_arbiter #(.LANES(4), .TS_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable_i),
        .tick_i     (tick_i),
        .key_in_i   (key_in_i),
        .clr_ovf_i  (clr_ovf_i),
        .game_time_o(game_time_o),
        .overflow_o (overflow_o),
        .ev         (ifc.master)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Reference model: per-lane pending flag and timestamp, last granted lane, output slot.
    logic [15:0] m_gt;
    logic [3:0]  m_keyq;
    logic [3:0]  m_pend;
    logic [15:0] m_ts [4];
    int          m_last;
    logic        m_valid;
    int          m_lane;
    logic [15:0] m_time;
    logic [3:0]  m_ovf;

    task automatic model_reset();
        m_gt = 0; m_keyq = 0; m_pend = 0; m_last = 3;
        m_valid = 0; m_lane = 0; m_time = 0; m_ovf = 0;
        for (int i = 0; i < 4; i++) m_ts[i] = 0;
    endtask

    // Advance the model with the current inputs, then let one clock edge pass.
    task automatic cyc();
        logic [3:0]  press;
        logic [3:0]  drop_set;
        logic [3:0]  pend_n;
        logic [15:0] ts_n [4];
        logic        ld;
        int          sel;
        int          l;
        press    = key_in_i & ~m_keyq & {4{enable_i}};
        ld       = !m_valid || ifc.ev_ready;
        sel      = -1;
        drop_set = 0;
        if (ld) begin
            for (int k = 1; k <= 4; k++) begin
                l = (m_last + k) % 4;
                if (sel < 0 && m_pend[l]) sel = l;
            end
        end
        for (int i = 0; i < 4; i++) begin
            ts_n[i]   = m_ts[i];
            pend_n[i] = m_pend[i] && (sel != i);
            if (press[i]) begin
                if (pend_n[i]) drop_set[i] = 1'b1;
                else begin
                    pend_n[i] = 1'b1;
                    ts_n[i]   = m_gt;
                end
            end
        end
        if (sel >= 0) begin
            m_valid = 1; m_lane = sel; m_time = m_ts[sel]; m_last = sel;
        end else if (ld) begin
            m_valid = 0;
        end
        m_ovf  = (m_ovf & ~{4{clr_ovf_i}}) | drop_set;
        m_pend = pend_n;
        for (int i = 0; i < 4; i++) m_ts[i] = ts_n[i];
        m_gt   = m_gt + 16'(tick_i);
        m_keyq = key_in_i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifc.ev_ready = 1'b0;
        tick_i   = 1'b1;
        key_in_i = 4'hF;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (game_time_o !== 16'd0) begin errs++; $display("FAIL reset_game_time got %0d want 0", game_time_o); end
        vec++; if (ifc.ev_valid !== 1'b0) begin errs++; $display("FAIL reset_ev_valid got %b want 0", ifc.ev_valid); end
        vec++; if (ifc.ev_lane !== 2'd0) begin errs++; $display("FAIL reset_ev_lane got %0d want 0", ifc.ev_lane); end
        vec++; if (ifc.ev_time !== 16'd0) begin errs++; $display("FAIL reset_ev_time got %0d want 0", ifc.ev_time); end
        vec++; if (ifc.ev_release !== 1'b0) begin errs++; $display("FAIL reset_ev_release got %b want 0", ifc.ev_release); end
        vec++; if (overflow_o !== 4'h0) begin errs++; $display("FAIL reset_overflow got %b want 0000", overflow_o); end
        model_reset();
        key_in_i = 4'h0;
        rst_n    = 1'b1;
        repeat (5) cyc();
        tick_i = 1'b0;
        cyc();
        vec++; if (game_time_o !== 16'd5) begin errs++; $display("FAIL tick_count got %0d want 5", game_time_o); end
        vec++; if (ifc.ev_valid !== 1'b0) begin errs++; $display("FAIL idle_valid got %b want 0", ifc.ev_valid); end
    endtask

    task automatic test_round_robin();
        logic [15:0] base;
        ifc.ev_ready = 1'b1;
        for (int rnd = 0; rnd < 2; rnd++) begin
            base     = m_gt;
            key_in_i = 4'hF;
            cyc();
            for (int i = 0; i < 5; i++) begin
                cyc();
                vec++;
                if (i < 4) begin
                    if (ifc.ev_valid !== 1'b1 || ifc.ev_lane !== 2'(i) || ifc.ev_time !== base) begin
                        errs++;
                        $display("FAIL rr_round%0d_slot%0d got v=%b lane=%0d t=%0d want v=1 lane=%0d t=%0d",
                                 rnd, i, ifc.ev_valid, ifc.ev_lane, ifc.ev_time, i, base);
                    end
                end else if (ifc.ev_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL rr_round%0d_drain got v=%b want 0", rnd, ifc.ev_valid);
                end
            end
            key_in_i = 4'h0;
            tick_i   = 1'b1;
            cyc();
            cyc();
            tick_i = 1'b0;
        end
    endtask

    task automatic test_single_press();
        int nv;
        ifc.ev_ready = 1'b1;
        tick_i = 1'b1;
        while (m_gt != 16'd100) cyc();
        tick_i   = 1'b0;
        key_in_i = 4'b0001;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vec++;
            if (ifc.ev_valid !== 1'(i == 1)) begin
                errs++;
                $display("FAIL single_valid cycle%0d got %b want %b", i, ifc.ev_valid, (i == 1));
            end
            if (ifc.ev_valid === 1'b1) begin
                nv++;
                vec++;
                if (ifc.ev_lane !== 2'd0 || ifc.ev_time !== 16'd100) begin
                    errs++;
                    $display("FAIL single_event got lane=%0d t=%0d want lane=0 t=100", ifc.ev_lane, ifc.ev_time);
                end
            end
        end
        vec++; if (nv !== 1) begin errs++; $display("FAIL single_count got %0d want 1", nv); end
        key_in_i = 4'h0;
        cyc();
    endtask

    task automatic test_backpressure();
        logic [15:0] t0;
        logic [15:0] t1;
        ifc.ev_ready = 1'b0;
        tick_i   = 1'b1;
        t0       = m_gt;
        t1       = 16'd0;
        key_in_i = 4'b0100;
        cyc();
        key_in_i = 4'h0;
        cyc();
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (ifc.ev_valid !== 1'b1 || ifc.ev_lane !== 2'd2 || ifc.ev_time !== t0) begin
                errs++;
                $display("FAIL stall_hold cycle%0d got v=%b lane=%0d t=%0d want v=1 lane=2 t=%0d",
                         i, ifc.ev_valid, ifc.ev_lane, ifc.ev_time, t0);
            end
            key_in_i = (i == 1 || i == 3) ? 4'b0100 : 4'b0000;
            if (i == 1) t1 = m_gt;
            cyc();
        end
        vec++; if (overflow_o !== 4'b0100) begin errs++; $display("FAIL stall_overflow got %b want 0100", overflow_o); end
        tick_i       = 1'b0;
        ifc.ev_ready = 1'b1;
        cyc();
        vec++;
        if (ifc.ev_valid !== 1'b1 || ifc.ev_lane !== 2'd2 || ifc.ev_time !== t1) begin
            errs++;
            $display("FAIL stall_second got v=%b lane=%0d t=%0d want v=1 lane=2 t=%0d",
                     ifc.ev_valid, ifc.ev_lane, ifc.ev_time, t1);
        end
        cyc();
        vec++; if (ifc.ev_valid !== 1'b0) begin errs++; $display("FAIL stall_dropped_emitted got v=%b want 0", ifc.ev_valid); end
        clr_ovf_i = 1'b1;
        cyc();
        clr_ovf_i = 1'b0;
        vec++; if (overflow_o !== 4'b0000) begin errs++; $display("FAIL clr_overflow got %b want 0000", overflow_o); end
    endtask

    task automatic test_enable();
        logic [15:0] tv;
        ifc.ev_ready = 1'b1;
        enable_i = 1'b0;
        key_in_i = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) enable_i = 1'b1;
            cyc();
            vec++;
            if (ifc.ev_valid !== 1'b0) begin
                errs++;
                $display("FAIL enable_gate cycle%0d got v=%b want 0", i, ifc.ev_valid);
            end
        end
        key_in_i = 4'h0;
        cyc();
        key_in_i = 4'b0010;
        tv = m_gt;
        cyc();
        cyc();
        vec++;
        if (ifc.ev_valid !== 1'b1 || ifc.ev_lane !== 2'd1 || ifc.ev_time !== tv) begin
            errs++;
            $display("FAIL enable_new_edge got v=%b lane=%0d t=%0d want v=1 lane=1 t=%0d",
                     ifc.ev_valid, ifc.ev_lane, ifc.ev_time, tv);
        end
        key_in_i = 4'h0;
        cyc();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) key_in_i = 4'($urandom);
            enable_i     = ($urandom_range(0, 7) != 0);
            tick_i       = 1'($urandom_range(0, 1));
            ifc.ev_ready = ($urandom_range(0, 1) != 0);
            clr_ovf_i    = ($urandom_range(0, 15) == 0);
            cyc();
            vec++;
            if (ifc.ev_valid !== m_valid || game_time_o !== m_gt || overflow_o !== m_ovf ||
                (m_valid && (ifc.ev_lane !== 2'(m_lane) || ifc.ev_time !== m_time))) begin
                errs++;
                $display("FAIL random_cycle%0d got v=%b lane=%0d t=%0d gt=%0d ovf=%b want v=%b lane=%0d t=%0d gt=%0d ovf=%b",
                         n, ifc.ev_valid, ifc.ev_lane, ifc.ev_time, game_time_o, overflow_o,
                         m_valid, m_lane, m_time, m_gt, m_ovf);
            end
        end
        key_in_i = 4'h0; enable_i = 1'b1; tick_i = 1'b0; clr_ovf_i = 1'b0; ifc.ev_ready = 1'b1;
        repeat (6) cyc();
    endtask

    task automatic test_wrap();
        tick_i = 1'b1;
        while (m_gt != 16'hFFFF) cyc();
        vec++; if (game_time_o !== 16'hFFFF) begin errs++; $display("FAIL wrap_top got %h want ffff", game_time_o); end
        cyc();
        tick_i = 1'b0;
        vec++; if (game_time_o !== 16'h0000) begin errs++; $display("FAIL wrap_zero got %h want 0000", game_time_o); end
    endtask

    task automatic test_release();
        logic [15:0] ta;
        logic [15:0] tb;
        logic [1:0]  lanes [4];
        logic [15:0] times [4];
        logic        rels  [4];
        int          n;
        ifc.ev_ready = 1'b1;
        n = 0;
        ta = m_gt;
        key_in_i = 4'b1000;
        for (int i = 0; i < 22; i++) begin
            if (i == 1) tick_i = 1'b1;
            if (i == 11) begin
                tick_i   = 1'b0;
                key_in_i = 4'b0000;
                tb       = m_gt;
            end
            cyc();
            if (ifc.ev_valid === 1'b1 && n < 4) begin
                lanes[n] = ifc.ev_lane; times[n] = ifc.ev_time; rels[n] = ifc.ev_release; n++;
            end
        end
        vec++; if (n !== 2) begin errs++; $display("FAIL release_count got %0d want 2", n); end
        vec++;
        if (n < 1 || lanes[0] !== 2'd3 || times[0] !== ta || rels[0] !== 1'b0) begin
            errs++; $display("FAIL release_press_event got n=%0d want lane=3 t=%0d rel=0", n, ta);
        end
        vec++;
        if (n < 2 || lanes[1] !== 2'd3 || times[1] !== tb || rels[1] !== 1'b1) begin
            errs++; $display("FAIL release_tail_event got n=%0d want lane=3 t=%0d rel=1", n, tb);
        end
    endtask

    initial begin
        test_reset();
`ifdef LANE_RELEASE_EVT_EN
        test_release();
`else
        test_round_robin();
        test_single_press();
        test_backpressure();
        test_enable();
        test_random();
        test_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/lane_event_arbiter.md
Name: lane_event_arbiter

Overview:
- Converts the four level-type lane key signals (a/s/k/l, lanes 0..3) from the keyboard front end into timestamped press events.
- Arbitrates the events round-robin onto a single valid/ready stream feeding the shared hit-judgement/score unit.
- Sits between kb_top and the judge. Guarantees each press is judged once, in fair order, with the game time at which it was pressed.

Parameters:
- LANES, 4, number of lanes/key inputs.
- TS_W, 16, width of game-time counter and event timestamp.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- enable  input  1  1 = capture new presses; 0 = ignore new presses (pending events still drain).
- tick  input  1  single-cycle game-time advance strobe.
- key_in  input  LANES  lane key levels, synchronous to clk, bit0 = a ... bit3 = l.
- ev_valid  output  1  event available.
- ev_ready  input  1  judge accepts event.
- ev_lane  output  2  lane index of event.
- ev_time  output  TS_W  game time captured at press.
- ev_release  output  1  1 = release event (see Optional Feature).
- game_time  output  TS_W  current game-time counter.
- overflow  output  LANES  sticky per-lane dropped-event flag.
- clr_ovf  input  1  clears all overflow bits.

Behaviour:
- Reset values (rst low, asynchronous):
  - Outputs: ev_valid, ev_lane, ev_time, ev_release, game_time and overflow all 0.
  - Internal: key_q, pending and stored timestamps 0; round-robin pointer favours lane 0.
- game_time:
  - Increments by 1 on each clk edge with tick=1.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Edge detect:
  - key_q registers key_in every cycle regardless of enable.
  - press[l] = key_in[l] & ~key_q[l] & enable.
  - A held key yields exactly one press.
- Capture:
  - On press[l], pending[l] is set and ts[l] takes game_time as seen in that cycle (the pre-increment value if tick is also high).
  - One pending slot per lane.
- Overflow:
  - If press[l] occurs while pending[l]=1 and lane l is not being loaded into the output that cycle, the new press is dropped, the old timestamp is kept and overflow[l] is set.
  - If lane l is loaded into the output in the same cycle, the new press is captured normally.
- Output register handshake:
  - Load allowed when ev_valid=0, or when ev_valid & ev_ready (back-to-back, one event per cycle).
  - Transfer completes on ev_valid & ev_ready at a clk edge.
  - While ev_valid=1 & ev_ready=0, ev_lane/ev_time/ev_release hold stable.
- Arbitration (two states):
  - IDLE = output empty; HOLD = ev_valid=1 awaiting ready.
  - When a load is allowed and any pending bit is set, select the first pending lane searching from (last granted + 1) mod LANES upward, wrapping.
  - On selection: load ev_* from that lane, clear its pending bit, advance the pointer to it, set ev_valid (go to HOLD).
  - If nothing is pending on a completed transfer, ev_valid drops (go to IDLE).
- Latency:
  - key_in rising sampled at edge N sets pending at edge N.
  - With the output empty, ev_valid=1 after edge N+1.
- Simultaneous presses on several lanes are all captured in the same cycle and emitted on consecutive accepted cycles in round-robin order.
- enable low mid-operation: pending events and the output drain normally; no new captures occur.
- overflow: a set takes priority over clr_ovf in the same cycle for that bit.

Optional Feature:
- LANE_RELEASE_EVT_EN defined:
  - A falling edge (~key_in[l] & key_q[l] & enable) also creates an event with ev_release=1, for hold-note tails.
  - Each lane gains a second pending slot (release). Press and release slots are arbitrated as separate requesters, in the order lane0-press, lane0-release, lane1-press, ...
  - Overflow applies per slot, reported OR-ed per lane.
- Not defined: ev_release is tied 0 and falling edges are ignored.

Test Plan:
- Reset, tick pulses: rst low, then 5 ticks -> game_time=5; all outputs 0 during reset; ev_valid stays 0.
- Single press: game_time=100, key_in=0001 held 10 cycles, ev_ready=1 -> exactly one event, lane 0, ev_time=100, ev_valid high 2 cycles after the rising edge, for 1 cycle.
- Round-robin: key_in 0000->1111 in one cycle, ev_ready=1 -> lanes 0,1,2,3 on 4 consecutive cycles, all with the same ev_time. Repeat -> order starts at lane 0 again (pointer after lane 3).
- Backpressure: ev_ready=0 with a lane-2 event held 6 cycles -> ev_lane/ev_time stable. A second lane-2 press during the stall -> overflow=0100; after ready, only the first timestamp is emitted. clr_ovf -> overflow=0000.
- Wrap and enable: game_time at 0xFFFF with tick -> 0x0000. enable=0 during a press on lane 1 -> no event. Re-enable while the key is still held -> no event until a new rising edge.
- With LANE_RELEASE_EVT_EN: press lane 3 at t=10, release at t=20 -> events (3, 10, rel=0) then (3, 20, rel=1).
